clock_display_scan: RTL

- Downstream consumer of the HH:MM:SS BCD counter chain.
- Time-multiplexes six BCD digits onto one common 7-segment bus with one-hot digit enables.
- Snapshots the time once per frame to prevent tearing. Inserts dead time between digits to suppress ghosting.
- Output drives the display pins directly.

---
 rtl/clock_display_scan.sv | 107 ++++++++++
 1 files changed

// File: rtl/clock_display_scan.sv
`timescale 1ns/1ps
// Six-digit multiplexed 7-segment scanner for the HH:MM:SS BCD chain.
// Time is snapshotted once per frame; each digit slot opens with dead time.
module clock_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [7:0] i_bcd_hours,
    input  logic [7:0] i_bcd_minutes,
    input  logic [7:0] i_bcd_seconds,
    input  logic       i_blank_lz,
    input  logic       i_sep,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [5:0] o_dig_sel,
    output logic       o_frame
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK    = CW'(BLANK_CYCLES);

    logic [CW-1:0] div_cnt;
    logic [2:0]    slot;
    logic [23:0]   snapshot;

    logic [3:0] digit;
    logic       capture;
    logic       show;
    logic       lz_dark;
    logic       sep_slot;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        digit = 4'h0;
        unique case (slot)
            3'd0:    digit = snapshot[23:20];
            3'd1:    digit = snapshot[19:16];
            3'd2:    digit = snapshot[15:12];
            3'd3:    digit = snapshot[11:8];
            3'd4:    digit = snapshot[7:4];
            3'd5:    digit = snapshot[3:0];
            default: digit = 4'h0;
        endcase
    end

    assign capture  = i_en && (div_cnt == '0) && (slot == 3'd0);
    assign show     = i_en && (div_cnt >= BLANK);
    assign lz_dark  = i_blank_lz && (slot == 3'd0) && (digit == 4'h0);
    assign sep_slot = (slot == 3'd1) || (slot == 3'd3);

    // Capture edge always falls in dead time, so stale snapshot is never shown.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt   <= '0;
            slot      <= 3'd0;
            snapshot  <= 24'h0;
            o_seg     <= 7'h00;
            o_dp      <= 1'b0;
            o_dig_sel <= 6'h00;
            o_frame   <= 1'b0;
        end else begin
            o_frame <= capture;
            if (capture) begin
                snapshot <= {i_bcd_hours, i_bcd_minutes, i_bcd_seconds};
            end
            if (i_en) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    slot    <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            if (show) begin
                o_dig_sel <= 6'b000001 << slot;
                o_seg     <= lz_dark ? 7'h00 : decode(digit);
                o_dp      <= i_sep && sep_slot;
            end else begin
                o_dig_sel <= 6'h00;
                o_seg     <= 7'h00;
                o_dp      <= 1'b0;
            end
        end
    end

endmodule
